// File: rtl/dendy_pkg.sv
// -----------------------------------------------------------------------------
// dendy_pkg
// Shared definitions for the Dendy/NES controller path.
//   joy_state_e      : states of the joypad poll frame sequencer
//   BTN_A..BTN_RIGHT : bit positions of each button in joy1/joy2
//   NUM_BUTTONS      : buttons shifted out of one 4021 per frame
// -----------------------------------------------------------------------------
package dendy_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    BIT_LO = 3'd2,
    BIT_HI = 3'd3,
    DONE   = 3'd4
  } joy_state_e;

  // Button order matches the order the 4021 presents them on Q8.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int NUM_BUTTONS = 8;

endpackage : dendy_pkg

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for one asynchronous level input.
//   clock25 : destination clock, rising edge
//   reset   : asynchronous active-high reset, forces both flops to 1
//   d       : asynchronous input
//   q       : synchronized output
// Reset value is 1 because an idle (unpressed or absent) pad line is high.
// -----------------------------------------------------------------------------
module sync2 (
  input  logic clock25,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule : sync2

// File: rtl/joypad_reader.sv
// -----------------------------------------------------------------------------
// joypad_reader
// Periodically polls two NES/Dendy pads (CD4021 shift registers): pulses
// joy_latch, clocks out 8 bits with joy_clk and publishes both button bytes
// atomically together with a one-cycle joy_valid pulse.
//   HALF_BIT  : clock25 cycles per latch / clock half-phase (4..1023)
//   POLL_DIV  : clock25 cycles between poll ticks (> 16*HALF_BIT)
//   clock25   : sole clock, rising edge
//   reset     : asynchronous active-high reset
//   enable    : permits a new poll frame to start
//   joy_d1/2  : serial pad data, low = pressed, asynchronous
//   joy_latch : parallel-load strobe to both pads (registered)
//   joy_clk   : shift clock to both pads (registered)
//   joy1/joy2 : button bytes, 1 = pressed, bit order per dendy_pkg
//   joy_valid : one-cycle pulse in the cycle joy1/joy2 take new values
// -----------------------------------------------------------------------------
module joypad_reader
  import dendy_pkg::*;
#(
  parameter int HALF_BIT = 150,
  parameter int POLL_DIV = 416667
) (
  input  logic       clock25,
  input  logic       reset,
  input  logic       enable,
  input  logic       joy_d1,
  input  logic       joy_d2,
  output logic       joy_latch,
  output logic       joy_clk,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic       joy_valid
);

  localparam int                POLL_W     = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_DIV - 1);
  localparam logic [9:0]        PHASE_LAST = 10'(HALF_BIT - 1);
  localparam logic [2:0]        INDEX_LAST = 3'(BTN_RIGHT);

  logic              d1_sync_s;
  logic              d2_sync_s;
  logic [POLL_W-1:0] poll_cnt_r;
  logic              tick_s;

  joy_state_e        state_r;
  joy_state_e        state_nxt_s;
  logic [9:0]        phase_r;
  logic [9:0]        phase_nxt_s;
  logic [2:0]        index_r;
  logic [2:0]        index_nxt_s;
  logic [7:0]        shift1_r;
  logic [7:0]        shift2_r;
  logic [7:0]        shift1_nxt_s;
  logic [7:0]        shift2_nxt_s;
  logic              phase_last_s;

  logic              latch_r;
  logic              clk_r;
  logic              valid_r;
  logic [7:0]        joy1_r;
  logic [7:0]        joy2_r;

  sync2 u_sync_d1 (
    .clock25 (clock25),
    .reset   (reset),
    .d       (joy_d1),
    .q       (d1_sync_s)
  );

  sync2 u_sync_d2 (
    .clock25 (clock25),
    .reset   (reset),
    .d       (joy_d2),
    .q       (d2_sync_s)
  );

  // Free-running poll divider; runs regardless of state so the tick rate is fixed.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      poll_cnt_r <= {POLL_W{1'b0}};
    end else if (poll_cnt_r == POLL_LAST) begin
      poll_cnt_r <= {POLL_W{1'b0}};
    end else begin
      poll_cnt_r <= poll_cnt_r + POLL_W'(1);
    end
  end

  assign tick_s       = (poll_cnt_r == POLL_LAST);
  assign phase_last_s = (phase_r == PHASE_LAST);

  // Frame sequencer: next state, phase/index bookkeeping and bit capture.
  always_comb begin
    state_nxt_s  = state_r;
    phase_nxt_s  = phase_r + 10'd1;
    index_nxt_s  = index_r;
    shift1_nxt_s = shift1_r;
    shift2_nxt_s = shift2_r;
    case (state_r)
      IDLE: begin
        phase_nxt_s = 10'd0;
        index_nxt_s = 3'd0;
        // Ticks are only honoured here, so ticks during a frame are dropped.
        if (tick_s && enable) begin
          state_nxt_s = LATCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LATCH: begin
        if (phase_last_s) begin
          state_nxt_s = BIT_LO;
          phase_nxt_s = 10'd0;
          index_nxt_s = 3'd0;
        end else begin
          state_nxt_s = LATCH;
        end
      end
      BIT_LO: begin
        if (phase_last_s) begin
          // Sample at the end of the low phase so the pad output has had
          // a full half-bit plus synchronizer delay to settle.
          shift1_nxt_s[index_r] = ~d1_sync_s;
          shift2_nxt_s[index_r] = ~d2_sync_s;
          phase_nxt_s           = 10'd0;
          if (index_r == INDEX_LAST) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = BIT_HI;
          end
        end else begin
          state_nxt_s = BIT_LO;
        end
      end
      BIT_HI: begin
        if (phase_last_s) begin
          state_nxt_s = BIT_LO;
          phase_nxt_s = 10'd0;
          index_nxt_s = index_r + 3'd1;
        end else begin
          state_nxt_s = BIT_HI;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        phase_nxt_s = 10'd0;
        index_nxt_s = 3'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        phase_nxt_s = 10'd0;
        index_nxt_s = 3'd0;
      end
    endcase
  end

  // Sequencer state, counters and shift registers.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      phase_r  <= 10'd0;
      index_r  <= 3'd0;
      shift1_r <= 8'h00;
      shift2_r <= 8'h00;
    end else begin
      state_r  <= state_nxt_s;
      phase_r  <= phase_nxt_s;
      index_r  <= index_nxt_s;
      shift1_r <= shift1_nxt_s;
      shift2_r <= shift2_nxt_s;
    end
  end

  // Output registers decoded from the next state, so each strobe is a clean
  // flop output aligned with the state it belongs to. Latch and clock come
  // from disjoint states and therefore can never be high together.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      latch_r <= 1'b0;
      clk_r   <= 1'b0;
      valid_r <= 1'b0;
      joy1_r  <= 8'h00;
      joy2_r  <= 8'h00;
    end else begin
      latch_r <= (state_nxt_s == LATCH);
      clk_r   <= (state_nxt_s == BIT_HI);
      valid_r <= (state_nxt_s == DONE);
      // Publish from the next-value bus so the final bit captured on the
      // same edge is included and both pads update in the same cycle.
      if (state_nxt_s == DONE) begin
        joy1_r <= shift1_nxt_s;
        joy2_r <= shift2_nxt_s;
      end else begin
        joy1_r <= joy1_r;
        joy2_r <= joy2_r;
      end
    end
  end

  assign joy_latch = latch_r;
  assign joy_clk   = clk_r;
  assign joy_valid = valid_r;
  assign joy1      = joy1_r;
  assign joy2      = joy2_r;

endmodule : joypad_reader

// File: tb/tb_joypad_reader.sv
// -----------------------------------------------------------------------------
// tb_joypad_reader
// Directed bench for joypad_reader with HALF_BIT=4, POLL_DIV=100. Two
// behavioural CD4021 pad models feed the DUT; a negedge monitor measures
// strobe timing. Expected values are hand-derived button patterns.
// -----------------------------------------------------------------------------
module tb_joypad_reader;

  logic       clock25 = 1'b0;
  logic       reset;
  logic       enable;
  wire        joy_d1;
  wire        joy_d2;
  logic       joy_latch;
  logic       joy_clk;
  logic [7:0] joy1;
  logic [7:0] joy2;
  logic       joy_valid;

  int vectors     = 0;
  int miscompares = 0;

  joypad_reader #(
    .HALF_BIT (4),
    .POLL_DIV (100)
  ) dut (
    .clock25   (clock25),
    .reset     (reset),
    .enable    (enable),
    .joy_d1    (joy_d1),
    .joy_d2    (joy_d2),
    .joy_latch (joy_latch),
    .joy_clk   (joy_clk),
    .joy1      (joy1),
    .joy2      (joy2),
    .joy_valid (joy_valid)
  );

  always #5 clock25 = ~clock25;

  // Pad models: load inverted buttons on latch rise, shift toward Q8 on clock rise.
  logic [7:0] pat1    = 8'h00;
  logic [7:0] pat2    = 8'h00;
  logic       pads_on = 1'b1;
  logic [7:0] pad1_sr = 8'hFF;
  logic [7:0] pad2_sr = 8'hFF;

  always @(posedge joy_latch or posedge joy_clk) begin
    if (joy_latch) begin
      pad1_sr <= ~pat1;
      pad2_sr <= ~pat2;
    end else begin
      pad1_sr <= {1'b1, pad1_sr[7:1]};
      pad2_sr <= {1'b1, pad2_sr[7:1]};
    end
  end

  assign joy_d1 = pads_on ? pad1_sr[0] : 1'b1;
  assign joy_d2 = pads_on ? pad2_sr[0] : 1'b1;

  // Monitor sampled on the falling edge, away from DUT updates.
  int         cyc            = 0;
  int         latch_rises    = 0;
  int         latch_rise_cyc = 0;
  int         latch_len      = 0;
  int         latch_last_len = 0;
  int         clk_rises      = 0;
  int         clk_w          = 0;
  int         clk_bad_w      = 0;
  int         valid_cnt      = 0;
  int         valid_cyc      = 0;
  int         valid_wide     = 0;
  int         overlap        = 0;
  int         joy_glitch     = 0;
  logic       prev_latch     = 1'b0;
  logic       prev_clk       = 1'b0;
  logic       prev_valid     = 1'b0;
  logic [7:0] prev_joy1      = 8'h00;
  logic [7:0] prev_joy2      = 8'h00;

  always @(negedge clock25) begin
    cyc <= cyc + 1;
    if (joy_latch && !prev_latch) begin
      latch_rises    <= latch_rises + 1;
      latch_rise_cyc <= cyc;
      latch_len      <= 1;
    end else if (joy_latch) begin
      latch_len <= latch_len + 1;
    end
    if (!joy_latch && prev_latch) latch_last_len <= latch_len;
    if (joy_clk && !prev_clk) begin
      clk_rises <= clk_rises + 1;
      clk_w     <= 1;
    end else if (joy_clk) begin
      clk_w <= clk_w + 1;
    end
    if (!joy_clk && prev_clk && clk_w != 4) clk_bad_w <= clk_bad_w + 1;
    if (joy_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
    if (joy_valid && prev_valid) valid_wide <= valid_wide + 1;
    if (joy_latch && joy_clk) overlap <= overlap + 1;
    if ((joy1 != prev_joy1 || joy2 != prev_joy2) && !joy_valid && !reset)
      joy_glitch <= joy_glitch + 1;
    prev_latch <= joy_latch;
    prev_clk   <= joy_clk;
    prev_valid <= joy_valid;
    prev_joy1  <= joy1;
    prev_joy2  <= joy2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock25);
    #1;
  endtask

  // Returns the number of cycles until the next latch rise; a timeout counts as a miscompare.
  task automatic wait_latch(output int n);
    int start;
    start = latch_rises;
    n = 0;
    while (latch_rises == start && n < 400) begin
      step();
      n++;
    end
    check("latch_timeout", 32'(latch_rises != start), 32'd1);
  endtask

  task automatic wait_valid();
    int start;
    int n;
    start = valid_cnt;
    n = 0;
    while (valid_cnt == start && n < 400) begin
      step();
      n++;
    end
    check("valid_timeout", 32'(valid_cnt != start), 32'd1);
  endtask

  initial begin
    int n;
    int clk0;
    int prev_rise;
    int lr0;
    int vc0;
    int gl0;

    // Reset state.
    reset  = 1'b1;
    enable = 1'b1;
    pat1   = 8'h89;  // A + Start + Right
    pat2   = 8'h00;
    repeat (3) step();
    check("rst_latch", 32'(joy_latch), 32'd0);
    check("rst_clk",   32'(joy_clk),   32'd0);
    check("rst_joy1",  32'(joy1),      32'd0);
    check("rst_joy2",  32'(joy2),      32'd0);
    check("rst_valid", 32'(joy_valid), 32'd0);

    // First frame: latch in the cycle after the 100th-cycle tick.
    @(negedge clock25);
    reset = 1'b0;
    clk0  = clk_rises;
    wait_latch(n);
    check("first_latch_delay", 32'(n), 32'd100);
    wait_valid();
    check("f1_joy1",      32'(joy1), 32'h89);
    check("f1_joy2",      32'(joy2), 32'h00);
    check("f1_latch_len", 32'(latch_last_len), 32'd4);
    check("f1_clk_pulses", 32'(clk_rises - clk0), 32'd7);
    check("f1_clk_width", 32'(clk_bad_w), 32'd0);
    // Counting the LATCH entry cycle as cycle 1, joy_valid falls in cycle 65.
    check("f1_valid_pos", 32'(valid_cyc - latch_rise_cyc + 1), 32'd65);
    step();
    check("f1_valid_1cyc", 32'(joy_valid), 32'd0);
    check("f1_valid_wide", 32'(valid_wide), 32'd0);

    // Second frame: one poll period later.
    prev_rise = latch_rise_cyc;
    wait_valid();
    check("period", 32'(latch_rise_cyc - prev_rise), 32'd100);
    check("f2_joy1", 32'(joy1), 32'h89);

    // All pressed on pad 1, mixed pattern on pad 2.
    pat1 = 8'hFF;
    pat2 = 8'h52;
    wait_valid();
    check("ff_joy1", 32'(joy1), 32'hFF);
    check("ff_joy2", 32'(joy2), 32'h52);

    // enable low across two ticks: no frame, outputs hold.
    enable = 1'b0;
    lr0 = latch_rises;
    vc0 = valid_cnt;
    repeat (250) step();
    check("dis_latches", 32'(latch_rises - lr0), 32'd0);
    check("dis_valids",  32'(valid_cnt - vc0),   32'd0);
    check("dis_joy1",    32'(joy1), 32'hFF);

    // Drop enable in BIT_HI index 3 (cycle 33 after latch rise): frame completes.
    pat1   = 8'h89;
    enable = 1'b1;
    wait_latch(n);
    repeat (33) step();
    check("mid_in_bit_hi", 32'(joy_clk), 32'd1);
    enable = 1'b0;
    wait_valid();
    check("mid_dis_joy1", 32'(joy1), 32'h89);
    check("mid_dis_joy2", 32'(joy2), 32'h52);
    enable = 1'b1;

    // Pattern changed mid-frame: current frame keeps the latched data.
    gl0 = joy_glitch;
    wait_latch(n);
    repeat (20) step();
    pat1 = 8'h3C;
    check("chg_hold", 32'(joy1), 32'h89);
    wait_valid();
    check("chg_old_frame", 32'(joy1), 32'h89);
    wait_valid();
    check("chg_new_frame", 32'(joy1), 32'h3C);
    check("chg_no_glitch", 32'(joy_glitch - gl0), 32'd0);

    // Reset during BIT_LO index 5 (cycle 45 after latch rise).
    wait_latch(n);
    repeat (45) step();
    check("pre_rst_joy1", 32'(joy1), 32'h3C);
    #1 reset = 1'b1;
    #1;
    check("arst_latch", 32'(joy_latch), 32'd0);
    check("arst_clk",   32'(joy_clk),   32'd0);
    check("arst_joy1",  32'(joy1),      32'd0);
    check("arst_joy2",  32'(joy2),      32'd0);
    check("arst_valid", 32'(joy_valid), 32'd0);
    repeat (3) step();
    @(negedge clock25);
    reset = 1'b0;
    lr0   = latch_rises;
    wait_latch(n);
    check("rst2_latch_delay", 32'(n), 32'd100);
    wait_valid();
    check("rst2_frames", 32'(latch_rises - lr0), 32'd1);
    check("rst2_joy1",   32'(joy1), 32'h3C);
    check("rst2_joy2",   32'(joy2), 32'h52);

    // Data lines tied high (pads absent) read as nothing pressed.
    pads_on = 1'b0;
    wait_valid();
    check("nopad_joy1", 32'(joy1), 32'h00);
    check("nopad_joy2", 32'(joy2), 32'h00);
    check("no_overlap", 32'(overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_joypad_reader
